// File: rtl/voice_allocator_if.sv
// Command channel into the voice allocator: note on/off requests from the register file.
// A command transfers on a rising clk edge where cmd_valid and cmd_ready are both 1. The
// master holds cmd_on/cmd_note/cmd_step stable while cmd_valid is high and ready is low.
interface voice_allocator_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_on;
  logic [6:0]  cmd_note;
  logic [31:0] cmd_step;

  modport master (output cmd_valid, cmd_on, cmd_note, cmd_step, input cmd_ready);
  modport slave  (input cmd_valid, cmd_on, cmd_note, cmd_step, output cmd_ready);
endinterface

// File: rtl/voice_allocator.sv
// Polyphonic voice scheduler: maps note on/off commands onto NUM_VOICES DDS slots.
// Build macro VOICE_STEAL_EN: when defined, a full allocator steals the oldest voice; otherwise the note is dropped.
module voice_allocator #(
  parameter int NUM_VOICES = 4,
  parameter int AGE_W      = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     sample_tick,
  voice_allocator_if.slave         cmd,
  output logic [32*NUM_VOICES-1:0] voice_step,
  output logic [7*NUM_VOICES-1:0]  voice_note,
  output logic [NUM_VOICES-1:0]    voice_gate,
  output logic [NUM_VOICES-1:0]    voice_trig,
  output logic                     drop_pulse,
  output logic [3:0]               active_count,
  output logic [2:0]               dbg_state_o
);
  localparam int IDX_W = $clog2(NUM_VOICES);
  typedef logic [IDX_W-1:0] idx_t;
  localparam idx_t LAST_IDX = idx_t'(NUM_VOICES - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SCAN   = 3'd1,
    ST_COMMIT = 3'd2
`ifdef VOICE_STEAL_EN
    , ST_STEAL_MUTE = 3'd3,
    ST_WAIT_TICK    = 3'd4
`endif
  } state_e;

  state_e           state_q, state_d;
  idx_t             scan_idx_q, scan_idx_d, tgt_idx_q, tgt_idx_d;
  idx_t             ret_idx_q, ret_idx_d, free_idx_q, free_idx_d;
  logic             ret_hit_q, ret_hit_d, free_hit_q, free_hit_d;
  logic             lat_on_q, lat_on_d;
  logic [6:0]       lat_note_q, lat_note_d;
  logic [31:0]      lat_step_q, lat_step_d;
  logic [31:0]      step_q [NUM_VOICES];
  logic [31:0]      step_d [NUM_VOICES];
  logic [6:0]       note_q [NUM_VOICES];
  logic [6:0]       note_d [NUM_VOICES];
  logic [AGE_W-1:0] age_q  [NUM_VOICES];
  logic [AGE_W-1:0] age_d  [NUM_VOICES];
  logic [NUM_VOICES-1:0] gate_q, gate_d, trig_q, trig_d;
  logic             drop_q, drop_d, ready_q, ready_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             cur_gate, cur_ret, cur_free;

`ifdef VOICE_STEAL_EN
  idx_t             old_idx_q, old_idx_d;
  logic [AGE_W-1:0] old_age_q, old_age_d;
  logic             cur_old;
  // Strict compare keeps the lowest index on equal ages; voice 0 is the default victim.
  assign cur_old = cur_gate && (age_q[scan_idx_q] > old_age_q);
`else
  logic tick_unused;
  assign tick_unused = sample_tick;
`endif

  assign cur_gate = gate_q[scan_idx_q];
  assign cur_ret  = cur_gate && (note_q[scan_idx_q] == lat_note_q);
  assign cur_free = !cur_gate;

  always_comb begin
    state_d    = state_q;
    scan_idx_d = scan_idx_q;
    tgt_idx_d  = tgt_idx_q;
    ret_idx_d  = ret_idx_q;
    free_idx_d = free_idx_q;
    ret_hit_d  = ret_hit_q;
    free_hit_d = free_hit_q;
    lat_on_d   = lat_on_q;
    lat_note_d = lat_note_q;
    lat_step_d = lat_step_q;
    step_d     = step_q;
    note_d     = note_q;
    age_d      = age_q;
    gate_d     = gate_q;
    trig_d     = '0;
    drop_d     = 1'b0;
`ifdef VOICE_STEAL_EN
    old_idx_d  = old_idx_q;
    old_age_d  = old_age_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (cmd.cmd_valid && ready_q) begin
          lat_on_d   = cmd.cmd_on;
          lat_note_d = cmd.cmd_note;
          lat_step_d = cmd.cmd_step;
          scan_idx_d = '0;
          ret_hit_d  = 1'b0;
          free_hit_d = 1'b0;
`ifdef VOICE_STEAL_EN
          old_idx_d  = '0;
          old_age_d  = '0;
`endif
          state_d    = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (lat_on_q) begin
          if (cur_ret && !ret_hit_q) begin
            ret_hit_d = 1'b1;
            ret_idx_d = scan_idx_q;
          end
          if (cur_free && !free_hit_q) begin
            free_hit_d = 1'b1;
            free_idx_d = scan_idx_q;
          end
`ifdef VOICE_STEAL_EN
          if (cur_old) begin
            old_idx_d = scan_idx_q;
            old_age_d = age_q[scan_idx_q];
          end
`endif
        end else if (cur_ret) begin
          gate_d[scan_idx_q] = 1'b0;
        end
        // Final decision sees this cycle's candidate updates through the _d values.
        if (scan_idx_q == LAST_IDX) begin
          if (!lat_on_q) begin
            state_d = ST_IDLE;
          end else if (ret_hit_d) begin
            tgt_idx_d = ret_idx_d;
            state_d   = ST_COMMIT;
          end else if (free_hit_d) begin
            tgt_idx_d = free_idx_d;
            state_d   = ST_COMMIT;
          end else begin
`ifdef VOICE_STEAL_EN
            tgt_idx_d = old_idx_d;
            state_d   = ST_STEAL_MUTE;
`else
            drop_d    = 1'b1;
            state_d   = ST_IDLE;
`endif
          end
        end else begin
          scan_idx_d = scan_idx_q + idx_t'(1);
        end
      end
`ifdef VOICE_STEAL_EN
      ST_STEAL_MUTE: begin
        gate_d[tgt_idx_q] = 1'b0;
        state_d           = ST_WAIT_TICK;
      end
      ST_WAIT_TICK: begin
        if (sample_tick) state_d = ST_COMMIT;
      end
`endif
      ST_COMMIT: begin
        for (int i = 0; i < NUM_VOICES; i++) begin
          if (idx_t'(i) == tgt_idx_q) begin
            step_d[i] = lat_step_q;
            note_d[i] = lat_note_q;
            gate_d[i] = 1'b1;
            age_d[i]  = '0;
            trig_d[i] = 1'b1;
          end else if (gate_q[i] && (age_q[i] != {AGE_W{1'b1}})) begin
            age_d[i] = age_q[i] + AGE_W'(1);
          end
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    ready_d = (state_d == ST_IDLE);
    cnt_d   = '0;
    for (int i = 0; i < NUM_VOICES; i++) cnt_d = cnt_d + 4'(gate_q[i]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      scan_idx_q <= '0;
      tgt_idx_q  <= '0;
      ret_idx_q  <= '0;
      free_idx_q <= '0;
      ret_hit_q  <= 1'b0;
      free_hit_q <= 1'b0;
      lat_on_q   <= 1'b0;
      lat_note_q <= '0;
      lat_step_q <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        step_q[i] <= '0;
        note_q[i] <= '0;
        age_q[i]  <= '0;
      end
      gate_q     <= '0;
      trig_q     <= '0;
      drop_q     <= 1'b0;
      ready_q    <= 1'b0;
      cnt_q      <= '0;
`ifdef VOICE_STEAL_EN
      old_idx_q  <= '0;
      old_age_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      scan_idx_q <= scan_idx_d;
      tgt_idx_q  <= tgt_idx_d;
      ret_idx_q  <= ret_idx_d;
      free_idx_q <= free_idx_d;
      ret_hit_q  <= ret_hit_d;
      free_hit_q <= free_hit_d;
      lat_on_q   <= lat_on_d;
      lat_note_q <= lat_note_d;
      lat_step_q <= lat_step_d;
      step_q     <= step_d;
      note_q     <= note_d;
      age_q      <= age_d;
      gate_q     <= gate_d;
      trig_q     <= trig_d;
      drop_q     <= drop_d;
      ready_q    <= ready_d;
      cnt_q      <= cnt_d;
`ifdef VOICE_STEAL_EN
      old_idx_q  <= old_idx_d;
      old_age_q  <= old_age_d;
`endif
    end
  end

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_pack
    assign voice_step[32*g +: 32] = step_q[g];
    assign voice_note[7*g +: 7]   = note_q[g];
  end

  assign voice_gate    = gate_q;
  assign voice_trig    = trig_q;
  assign drop_pulse    = drop_q;
  assign active_count  = cnt_q;
  assign cmd.cmd_ready = ready_q;
  assign dbg_state_o   = state_q;
endmodule
